// File: rtl/memory_stream_reader.sv
// Read-side initiator: sweeps len words from baseAdr (wrapping) out of a 1-cycle-latency
// memory and presents them in order on a valid/ready stream through a 2-entry skid buffer.
module memory_stream_reader #(
    parameter int WordSize  = 32,
    parameter int WordCount = 128,
    localparam int AW = (WordCount > 1) ? $clog2(WordCount) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW-1:0]       baseAdr,
    input  logic [AW:0]         len,
    output logic [AW-1:0]       memAdr,
    output logic                memWrite,
    output logic                memClr,
    input  logic [WordSize-1:0] memData,
    output logic [WordSize-1:0] outData,
    output logic                outValid,
    input  logic                outReady,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW:0]   LenMax  = (AW+1)'(WordCount);
    localparam logic [AW-1:0] LastAdr = AW'(WordCount - 1);

    state_t              state_r;
    state_t              stateNext_s;
    logic                accept_s;
    logic                busyNext_s;
    logic                doneNext_s;
    logic [AW:0]         toIssue_r;
    logic [AW:0]         toSend_r;
    logic                inFlight_r;
    logic [WordSize-1:0] slot1_r;
    logic [1:0]          occ_r;
    logic [1:0]          occNext_s;
    logic [AW:0]         lenEff_s;
    logic                pop_s;
    logic                issue_s;

    assign memWrite = 1'b0;
    assign memClr   = 1'b0;

    assign lenEff_s  = (len > LenMax) ? LenMax : len;
    assign pop_s     = outValid & outReady;
    // Occupancy after this edge if no new issue; an issue is safe only if it leaves room for its word.
    assign occNext_s = occ_r + {1'b0, inFlight_r} - {1'b0, pop_s};
    assign issue_s   = (state_r == RUN) && (toIssue_r != {(AW+1){1'b0}}) && (occNext_s <= 2'd1);

    // Next-state and registered-output decode for the sweep controller.
    always_comb begin
        stateNext_s = state_r;
        accept_s    = 1'b0;
        busyNext_s  = busy;
        doneNext_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (lenEff_s != {(AW+1){1'b0}}) begin
                        accept_s    = 1'b1;
                        busyNext_s  = 1'b1;
                        stateNext_s = RUN;
                    end else begin
                        doneNext_s  = 1'b1;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            RUN: begin
                if (issue_s && (toIssue_r == (AW+1)'(1))) begin
                    stateNext_s = DRAIN;
                end else begin
                    stateNext_s = RUN;
                end
            end
            DRAIN: begin
                if (toSend_r == {(AW+1){1'b0}}) begin
                    doneNext_s  = 1'b1;
                    busyNext_s  = 1'b0;
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = DRAIN;
                end
            end
            default: begin
                busyNext_s  = 1'b0;
                stateNext_s = IDLE;
            end
        endcase
    end

    // State register, address/counter tracking and skid buffer update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            memAdr     <= {AW{1'b0}};
            toIssue_r  <= {(AW+1){1'b0}};
            toSend_r   <= {(AW+1){1'b0}};
            inFlight_r <= 1'b0;
            outData    <= {WordSize{1'b0}};
            slot1_r    <= {WordSize{1'b0}};
            occ_r      <= 2'd0;
            outValid   <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            busy       <= busyNext_s;
            done       <= doneNext_s;
            inFlight_r <= issue_s;
            if (accept_s) begin
                memAdr    <= baseAdr;
                toIssue_r <= lenEff_s;
                toSend_r  <= lenEff_s;
            end else begin
                if (issue_s) begin
                    memAdr    <= (memAdr == LastAdr) ? {AW{1'b0}} : memAdr + AW'(1);
                    toIssue_r <= toIssue_r - (AW+1)'(1);
                end
                if (pop_s) begin
                    toSend_r <= toSend_r - (AW+1)'(1);
                end
            end
            // Head register is outData; the second entry only fills when the head is occupied.
            case ({inFlight_r, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        outData <= memData;
                    end else begin
                        slot1_r <= memData;
                    end
                end
                2'b01: begin
                    outData <= slot1_r;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        outData <= memData;
                    end else begin
                        outData <= slot1_r;
                        slot1_r <= memData;
                    end
                end
                default: begin
                end
            endcase
            occ_r    <= occNext_s;
            outValid <= (occNext_s != 2'd0);
        end
    end

endmodule

// File: tb/tb_memory_stream_reader.sv
// Directed bench for memory_stream_reader with a behavioural 1-cycle-latency word memory.
module tb_memory_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  baseAdr;
    logic [7:0]  len;
    logic [6:0]  memAdr;
    logic        memWrite;
    logic        memClr;
    logic [31:0] memData;
    logic [31:0] outData;
    logic        outValid;
    logic        outReady;
    logic        busy;
    logic        done;

    logic [31:0] mem [128];
    int total = 0;
    int bad   = 0;

    memory_stream_reader #(.WordSize(32), .WordCount(128)) dut (
        .clk(clk), .rst(rst), .start(start), .baseAdr(baseAdr), .len(len),
        .memAdr(memAdr), .memWrite(memWrite), .memClr(memClr), .memData(memData),
        .outData(outData), .outValid(outValid), .outReady(outReady),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) memData <= mem[memAdr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [6:0] b, input logic [7:0] l);
        baseAdr = b;
        len     = l;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    logic [15:0] readyPat;
    int          got;
    int          cyc;
    logic [31:0] held;
    logic        stalled;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'(i + 100);
        rst = 1'b0; start = 1'b0; baseAdr = 7'd0; len = 8'd0; outReady = 1'b1;
        tick(); tick();
        check("rst_outValid", {31'd0, outValid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_memAdr", {25'd0, memAdr}, 32'd0);
        check("rst_outData", outData, 32'd0);
        check("memWrite_tied", {30'd0, memWrite, memClr}, 32'd0);
        rst = 1'b1;
        tick();

        // 1) basic sweep, full throughput
        go(7'd5, 8'd4);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_adr0", {25'd0, memAdr}, 32'd5);
        check("t1_noValid0", {31'd0, outValid}, 32'd0);
        tick();
        check("t1_noValid1", {31'd0, outValid}, 32'd0);
        tick();
        check("t1_valid", {31'd0, outValid}, 32'd1);
        check("t1_d0", outData, 32'd105);
        tick(); check("t1_d1", outData, 32'd106);
        tick(); check("t1_d2", outData, 32'd107);
        tick(); check("t1_d3", outData, 32'd108);
        check("t1_d3_noDone", {31'd0, done}, 32'd0);
        tick();
        check("t1_empty", {31'd0, outValid}, 32'd0);
        check("t1_notYetDone", {31'd0, done}, 32'd0);
        tick();
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_idle", {31'd0, busy}, 32'd0);
        tick();
        check("t1_donePulse", {31'd0, done}, 32'd0);

        // 2) address wrap at the top of memory
        go(7'd126, 8'd4);
        check("t2_adr126", {25'd0, memAdr}, 32'd126);
        tick(); check("t2_adr127", {25'd0, memAdr}, 32'd127);
        tick(); check("t2_adr0", {25'd0, memAdr}, 32'd0);
        check("t2_d126", outData, 32'd226);
        tick(); check("t2_adr1", {25'd0, memAdr}, 32'd1);
        check("t2_d127", outData, 32'd227);
        tick(); check("t2_d0", outData, 32'd100);
        tick(); check("t2_d1", outData, 32'd101);
        tick(); tick();
        check("t2_done", {31'd0, done}, 32'd1);
        tick();

        // 4) zero-length sweep
        go(7'd9, 8'd0);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_valid", {31'd0, outValid}, 32'd0);
        tick();
        check("t4_donePulse", {31'd0, done}, 32'd0);
        check("t4_valid2", {31'd0, outValid}, 32'd0);

        // 3) backpressure: order, no loss/duplication, stability while stalled
        readyPat = 16'b1010_0110_1101_1001;
        got = 0; stalled = 1'b0; held = 32'd0;
        go(7'd10, 8'd8);
        for (cyc = 0; cyc < 60 && !done; cyc++) begin
            if (stalled) begin
                check("t3_holdValid", {31'd0, outValid}, 32'd1);
                check("t3_holdData", outData, held);
            end
            outReady = readyPat[cyc % 16];
            stalled  = outValid & ~outReady;
            held     = outData;
            if (outValid && outReady) begin
                check("t3_order", outData, 32'(110 + got));
                got++;
            end
            tick();
        end
        check("t3_doneSeen", {31'd0, done}, 32'd1);
        check("t3_count", 32'(got), 32'd8);
        outReady = 1'b1;
        tick();

        // 5) reset mid-sweep, then a clean restart
        go(7'd20, 8'd10);
        tick(); tick(); tick(); tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_valid", {31'd0, outValid}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_adr", {25'd0, memAdr}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        tick();
        check("t5_noDone", {31'd0, done}, 32'd0);
        go(7'd0, 8'd2);
        tick(); tick();
        check("t5_d0", outData, 32'd100);
        tick(); check("t5_d1", outData, 32'd101);
        tick(); tick();
        check("t5_done2", {31'd0, done}, 32'd1);
        tick();

        // 6) start while busy is ignored; start during done begins a new sweep
        go(7'd40, 8'd3);
        baseAdr = 7'd0; len = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_ignoreAdr", {25'd0, memAdr}, 32'd41);
        tick(); check("t6_d0", outData, 32'd140);
        tick(); check("t6_d1", outData, 32'd141);
        tick(); check("t6_d2", outData, 32'd142);
        tick(); check("t6_empty", {31'd0, outValid}, 32'd0);
        tick(); check("t6_done", {31'd0, done}, 32'd1);
        baseAdr = 7'd50; len = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_reBusy", {31'd0, busy}, 32'd1);
        check("t6_reAdr", {25'd0, memAdr}, 32'd50);
        tick(); tick();
        check("t6_reValid", {31'd0, outValid}, 32'd1);
        check("t6_reData", outData, 32'd150);
        tick(); tick();
        check("t6_reDone", {31'd0, done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
